// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station for one functional unit: oldest-ready-first issue, broadcast wakeup, full flush.
// Optional RS_WAKEUP_BYPASS_EN: same-cycle broadcasts also make entries ready and are forwarded to the issue outputs.
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif

package rs_age_ordered_pkg;
   typedef logic [3:0] fu_op_t;
   typedef logic [3:0] nzcv_t;
   typedef logic [3:0] cond_t;
endpackage

module rs_age_ordered
   import rs_age_ordered_pkg::*;
#(
   parameter int RS_SIZE      = 8,
   parameter int RS_IDX_SIZE  = $clog2(RS_SIZE),
   parameter int NUM_BCAST    = 2,
   parameter int ROB_IDX_SIZE = `ROB_IDX_SIZE,
   parameter int GPR_SIZE     = `GPR_SIZE
) (
   input  logic                              in_clk,
   input  logic                              in_rst_n,
   input  logic                              in_disp_valid,
   output logic                              out_disp_ready,
   input  fu_op_t                            in_disp_op,
   input  logic [ROB_IDX_SIZE-1:0]           in_disp_dst_rob_index,
   input  logic                              in_disp_a_valid,
   input  logic                              in_disp_b_valid,
   input  logic [GPR_SIZE-1:0]               in_disp_a_value,
   input  logic [GPR_SIZE-1:0]               in_disp_b_value,
   input  logic [ROB_IDX_SIZE-1:0]           in_disp_a_rob_index,
   input  logic [ROB_IDX_SIZE-1:0]           in_disp_b_rob_index,
   input  logic                              in_disp_uses_nzcv,
   input  logic                              in_disp_set_nzcv,
   input  logic                              in_disp_nzcv_valid,
   input  nzcv_t                             in_disp_nzcv,
   input  logic [ROB_IDX_SIZE-1:0]           in_disp_nzcv_rob_index,
   input  cond_t                             in_disp_cond,
   input  logic [NUM_BCAST-1:0]              in_bcast_valid,
   input  logic [NUM_BCAST*ROB_IDX_SIZE-1:0] in_bcast_index,
   input  logic [NUM_BCAST*GPR_SIZE-1:0]     in_bcast_value,
   input  logic [NUM_BCAST-1:0]              in_bcast_set_nzcv,
   input  logic [NUM_BCAST*4-1:0]            in_bcast_nzcv,
   input  logic                              in_flush,
   input  logic                              in_fu_ready,
   output logic                              out_issue_valid,
   output fu_op_t                            out_issue_op,
   output logic [GPR_SIZE-1:0]               out_issue_val_a,
   output logic [GPR_SIZE-1:0]               out_issue_val_b,
   output logic [ROB_IDX_SIZE-1:0]           out_issue_dst_rob_index,
   output nzcv_t                             out_issue_nzcv,
   output logic                              out_issue_set_nzcv,
   output cond_t                             out_issue_cond,
   output logic [RS_IDX_SIZE:0]              out_occupancy
);

   localparam logic [RS_IDX_SIZE:0] RS_FULL = (RS_IDX_SIZE+1)'(RS_SIZE);

   typedef struct packed {
      logic                    valid;
      logic [RS_IDX_SIZE-1:0]  age;
      fu_op_t                  op;
      logic [ROB_IDX_SIZE-1:0] dst;
      logic                    aValid;
      logic [GPR_SIZE-1:0]     aValue;
      logic [ROB_IDX_SIZE-1:0] aTag;
      logic                    bValid;
      logic [GPR_SIZE-1:0]     bValue;
      logic [ROB_IDX_SIZE-1:0] bTag;
      logic                    usesNzcv;
      logic                    setNzcv;
      logic                    nzcvValid;
      nzcv_t                   nzcv;
      logic [ROB_IDX_SIZE-1:0] nzcvTag;
      cond_t                   cond;
   } entry_t;

   entry_t               entry_q [RS_SIZE];
   entry_t               entry_d [RS_SIZE];
   logic [RS_IDX_SIZE:0] occ_q, occ_d;

   logic [RS_SIZE-1:0]     aHit, bHit, fHit, entryReady;
   logic [GPR_SIZE-1:0]    aWake [RS_SIZE];
   logic [GPR_SIZE-1:0]    bWake [RS_SIZE];
   nzcv_t                  fWake [RS_SIZE];
   logic                   dispAHit, dispBHit, dispFHit;
   logic [GPR_SIZE-1:0]    dispAWake, dispBWake;
   nzcv_t                  dispFWake;
   logic                   selFound;
   logic [RS_IDX_SIZE-1:0] selIdx, selAge, freeIdx, dispAge;
   logic                   issueFire, dispFire;

   // Ports are scanned from the top down so the lowest-numbered matching port overwrites the rest.
   function automatic logic [GPR_SIZE:0] matchValue(
      input logic [ROB_IDX_SIZE-1:0]           tag,
      input logic [NUM_BCAST-1:0]              bv,
      input logic [NUM_BCAST*ROB_IDX_SIZE-1:0] bi,
      input logic [NUM_BCAST*GPR_SIZE-1:0]     bd
   );
      logic [GPR_SIZE:0] r;
      r = '0;
      for (int p = NUM_BCAST-1; p >= 0; p--) begin
         if (bv[p] && (bi[p*ROB_IDX_SIZE +: ROB_IDX_SIZE] == tag)) begin
            r = {1'b1, bd[p*GPR_SIZE +: GPR_SIZE]};
         end
      end
      return r;
   endfunction

   function automatic logic [4:0] matchFlags(
      input logic [ROB_IDX_SIZE-1:0]           tag,
      input logic [NUM_BCAST-1:0]              bv,
      input logic [NUM_BCAST*ROB_IDX_SIZE-1:0] bi,
      input logic [NUM_BCAST-1:0]              bs,
      input logic [NUM_BCAST*4-1:0]            bn
   );
      logic [4:0] r;
      r = '0;
      for (int p = NUM_BCAST-1; p >= 0; p--) begin
         if (bv[p] && bs[p] && (bi[p*ROB_IDX_SIZE +: ROB_IDX_SIZE] == tag)) begin
            r = {1'b1, bn[p*4 +: 4]};
         end
      end
      return r;
   endfunction

   // Broadcast matches for every stored entry and for the incoming dispatch; hits count only for waiting fields.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         {aHit[i], aWake[i]} = matchValue(entry_q[i].aTag, in_bcast_valid, in_bcast_index, in_bcast_value);
         {bHit[i], bWake[i]} = matchValue(entry_q[i].bTag, in_bcast_valid, in_bcast_index, in_bcast_value);
         {fHit[i], fWake[i]} = matchFlags(entry_q[i].nzcvTag, in_bcast_valid, in_bcast_index,
                                          in_bcast_set_nzcv, in_bcast_nzcv);
         aHit[i] = aHit[i] & entry_q[i].valid & ~entry_q[i].aValid;
         bHit[i] = bHit[i] & entry_q[i].valid & ~entry_q[i].bValid;
         fHit[i] = fHit[i] & entry_q[i].valid & ~entry_q[i].nzcvValid;
`ifdef RS_WAKEUP_BYPASS_EN
         entryReady[i] = entry_q[i].valid & (entry_q[i].aValid | aHit[i]) & (entry_q[i].bValid | bHit[i])
                       & (~entry_q[i].usesNzcv | entry_q[i].nzcvValid | fHit[i]);
`else
         entryReady[i] = entry_q[i].valid & entry_q[i].aValid & entry_q[i].bValid
                       & (~entry_q[i].usesNzcv | entry_q[i].nzcvValid);
`endif
      end
      {dispAHit, dispAWake} = matchValue(in_disp_a_rob_index, in_bcast_valid, in_bcast_index, in_bcast_value);
      {dispBHit, dispBWake} = matchValue(in_disp_b_rob_index, in_bcast_valid, in_bcast_index, in_bcast_value);
      {dispFHit, dispFWake} = matchFlags(in_disp_nzcv_rob_index, in_bcast_valid, in_bcast_index,
                                         in_bcast_set_nzcv, in_bcast_nzcv);
   end

   // Oldest ready entry wins; ages are unique so the first strict minimum is the only one.
   always_comb begin
      selFound = 1'b0;
      selIdx   = '0;
      selAge   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (entryReady[i] && (!selFound || (entry_q[i].age < selAge))) begin
            selFound = 1'b1;
            selIdx   = RS_IDX_SIZE'(i);
            selAge   = entry_q[i].age;
         end
      end
   end

   always_comb begin
      freeIdx = '0;
      for (int i = RS_SIZE-1; i >= 0; i--) begin
         if (!entry_q[i].valid) begin
            freeIdx = RS_IDX_SIZE'(i);
         end
      end
   end

   always_comb begin
      out_issue_op            = '0;
      out_issue_val_a         = '0;
      out_issue_val_b         = '0;
      out_issue_dst_rob_index = '0;
      out_issue_nzcv          = '0;
      out_issue_set_nzcv      = 1'b0;
      out_issue_cond          = '0;
      if (selFound) begin
         out_issue_op            = entry_q[selIdx].op;
         out_issue_dst_rob_index = entry_q[selIdx].dst;
         out_issue_set_nzcv      = entry_q[selIdx].setNzcv;
         out_issue_cond          = entry_q[selIdx].cond;
`ifdef RS_WAKEUP_BYPASS_EN
         out_issue_val_a = entry_q[selIdx].aValid    ? entry_q[selIdx].aValue : aWake[selIdx];
         out_issue_val_b = entry_q[selIdx].bValid    ? entry_q[selIdx].bValue : bWake[selIdx];
         out_issue_nzcv  = (entry_q[selIdx].nzcvValid || !fHit[selIdx]) ? entry_q[selIdx].nzcv : fWake[selIdx];
`else
         out_issue_val_a = entry_q[selIdx].aValue;
         out_issue_val_b = entry_q[selIdx].bValue;
         out_issue_nzcv  = entry_q[selIdx].nzcv;
`endif
      end
   end

   assign out_issue_valid = selFound;
   assign out_disp_ready  = (occ_q != RS_FULL);
   assign out_occupancy   = occ_q;
   assign issueFire       = selFound & in_fu_ready;
   assign dispFire        = in_disp_valid & out_disp_ready;
   // A new entry is younger than everything that survives this cycle's issue.
   assign dispAge         = RS_IDX_SIZE'(occ_q - (RS_IDX_SIZE+1)'(issueFire));

   always_comb begin
      occ_d = occ_q;
      for (int i = 0; i < RS_SIZE; i++) begin
         entry_d[i] = entry_q[i];
      end
      if (in_flush) begin
         occ_d = '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i].valid = 1'b0;
            entry_d[i].age   = '0;
         end
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (aHit[i]) begin
               entry_d[i].aValid = 1'b1;
               entry_d[i].aValue = aWake[i];
            end
            if (bHit[i]) begin
               entry_d[i].bValid = 1'b1;
               entry_d[i].bValue = bWake[i];
            end
            if (fHit[i]) begin
               entry_d[i].nzcvValid = 1'b1;
               entry_d[i].nzcv      = fWake[i];
            end
            if (issueFire && entry_q[i].valid && (entry_q[i].age > selAge)) begin
               entry_d[i].age = entry_q[i].age - RS_IDX_SIZE'(1);
            end
         end
         if (issueFire) begin
            entry_d[selIdx].valid = 1'b0;
         end
         if (dispFire) begin
            entry_d[freeIdx].valid     = 1'b1;
            entry_d[freeIdx].age       = dispAge;
            entry_d[freeIdx].op        = in_disp_op;
            entry_d[freeIdx].dst       = in_disp_dst_rob_index;
            entry_d[freeIdx].aValid    = in_disp_a_valid | dispAHit;
            entry_d[freeIdx].aValue    = in_disp_a_valid ? in_disp_a_value : dispAWake;
            entry_d[freeIdx].aTag      = in_disp_a_rob_index;
            entry_d[freeIdx].bValid    = in_disp_b_valid | dispBHit;
            entry_d[freeIdx].bValue    = in_disp_b_valid ? in_disp_b_value : dispBWake;
            entry_d[freeIdx].bTag      = in_disp_b_rob_index;
            entry_d[freeIdx].usesNzcv  = in_disp_uses_nzcv;
            entry_d[freeIdx].setNzcv   = in_disp_set_nzcv;
            entry_d[freeIdx].nzcvValid = in_disp_nzcv_valid | dispFHit;
            entry_d[freeIdx].nzcv      = in_disp_nzcv_valid ? in_disp_nzcv : dispFWake;
            entry_d[freeIdx].nzcvTag   = in_disp_nzcv_rob_index;
            entry_d[freeIdx].cond      = in_disp_cond;
         end
         occ_d = occ_q + (RS_IDX_SIZE+1)'(dispFire) - (RS_IDX_SIZE+1)'(issueFire);
      end
   end

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         occ_q <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         occ_q <= occ_d;
         for (int i = 0; i < RS_SIZE; i++) begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Bench for rs_age_ordered: directed scenarios plus random traffic, all checked against a dispatch-ordered queue model.
module tb_rs_age_ordered;
   import rs_age_ordered_pkg::*;

   localparam int RS = 8;
   localparam int NB = 2;
   localparam int RW = 5;
   localparam int GW = 32;

   logic              in_clk, in_rst_n, in_disp_valid, out_disp_ready;
   fu_op_t            in_disp_op;
   logic [RW-1:0]     in_disp_dst_rob_index, in_disp_a_rob_index, in_disp_b_rob_index, in_disp_nzcv_rob_index;
   logic              in_disp_a_valid, in_disp_b_valid;
   logic [GW-1:0]     in_disp_a_value, in_disp_b_value;
   logic              in_disp_uses_nzcv, in_disp_set_nzcv, in_disp_nzcv_valid;
   nzcv_t             in_disp_nzcv;
   cond_t             in_disp_cond;
   logic [NB-1:0]     in_bcast_valid, in_bcast_set_nzcv;
   logic [NB*RW-1:0]  in_bcast_index;
   logic [NB*GW-1:0]  in_bcast_value;
   logic [NB*4-1:0]   in_bcast_nzcv;
   logic              in_flush, in_fu_ready, out_issue_valid, out_issue_set_nzcv;
   fu_op_t            out_issue_op;
   logic [GW-1:0]     out_issue_val_a, out_issue_val_b;
   logic [RW-1:0]     out_issue_dst_rob_index;
   nzcv_t             out_issue_nzcv;
   cond_t             out_issue_cond;
   logic [3:0]        out_occupancy;

   rs_age_ordered #(.RS_SIZE(RS), .NUM_BCAST(NB), .ROB_IDX_SIZE(RW), .GPR_SIZE(GW)) dut (
      .in_clk(in_clk), .in_rst_n(in_rst_n),
      .in_disp_valid(in_disp_valid), .out_disp_ready(out_disp_ready),
      .in_disp_op(in_disp_op), .in_disp_dst_rob_index(in_disp_dst_rob_index),
      .in_disp_a_valid(in_disp_a_valid), .in_disp_b_valid(in_disp_b_valid),
      .in_disp_a_value(in_disp_a_value), .in_disp_b_value(in_disp_b_value),
      .in_disp_a_rob_index(in_disp_a_rob_index), .in_disp_b_rob_index(in_disp_b_rob_index),
      .in_disp_uses_nzcv(in_disp_uses_nzcv), .in_disp_set_nzcv(in_disp_set_nzcv),
      .in_disp_nzcv_valid(in_disp_nzcv_valid), .in_disp_nzcv(in_disp_nzcv),
      .in_disp_nzcv_rob_index(in_disp_nzcv_rob_index), .in_disp_cond(in_disp_cond),
      .in_bcast_valid(in_bcast_valid), .in_bcast_index(in_bcast_index),
      .in_bcast_value(in_bcast_value), .in_bcast_set_nzcv(in_bcast_set_nzcv),
      .in_bcast_nzcv(in_bcast_nzcv), .in_flush(in_flush), .in_fu_ready(in_fu_ready),
      .out_issue_valid(out_issue_valid), .out_issue_op(out_issue_op),
      .out_issue_val_a(out_issue_val_a), .out_issue_val_b(out_issue_val_b),
      .out_issue_dst_rob_index(out_issue_dst_rob_index), .out_issue_nzcv(out_issue_nzcv),
      .out_issue_set_nzcv(out_issue_set_nzcv), .out_issue_cond(out_issue_cond),
      .out_occupancy(out_occupancy)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   typedef struct {
      fu_op_t        op;
      logic [RW-1:0] dst;
      logic          av;
      logic [GW-1:0] aval;
      logic [RW-1:0] atag;
      logic          bv;
      logic [GW-1:0] bval;
      logic [RW-1:0] btag;
      logic          uses;
      logic          setf;
      logic          fv;
      nzcv_t         f;
      logic [RW-1:0] ftag;
      cond_t         cond;
   } mEntry_t;

   // The model queue is kept in dispatch order, so index 0 is always the oldest entry.
   mEntry_t mq[$];
   int checkCount = 0;
   int passCount  = 0;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, actual, expected, $time);
   endtask

   task automatic clearInputs();
      in_rst_n = 1'b1; in_disp_valid = 1'b0; in_disp_op = '0; in_disp_dst_rob_index = '0;
      in_disp_a_valid = 1'b0; in_disp_b_valid = 1'b0; in_disp_a_value = '0; in_disp_b_value = '0;
      in_disp_a_rob_index = '0; in_disp_b_rob_index = '0; in_disp_uses_nzcv = 1'b0;
      in_disp_set_nzcv = 1'b0; in_disp_nzcv_valid = 1'b1; in_disp_nzcv = '0;
      in_disp_nzcv_rob_index = '0; in_disp_cond = '0; in_bcast_valid = '0; in_bcast_index = '0;
      in_bcast_value = '0; in_bcast_set_nzcv = '0; in_bcast_nzcv = '0; in_flush = 1'b0; in_fu_ready = 1'b0;
   endtask

   task automatic setDispatch(input logic [3:0] op, input logic [RW-1:0] dst,
                              input logic av, input logic [GW-1:0] aval, input logic [RW-1:0] atag,
                              input logic bv, input logic [GW-1:0] bval, input logic [RW-1:0] btag);
      in_disp_valid = 1'b1; in_disp_op = op; in_disp_dst_rob_index = dst;
      in_disp_a_valid = av; in_disp_a_value = aval; in_disp_a_rob_index = atag;
      in_disp_b_valid = bv; in_disp_b_value = bval; in_disp_b_rob_index = btag;
   endtask

   task automatic setBcast(input int p, input logic [RW-1:0] idx, input logic [GW-1:0] val);
      in_bcast_valid[p] = 1'b1;
      in_bcast_index[p*RW +: RW] = idx;
      in_bcast_value[p*GW +: GW] = val;
   endtask

   function automatic bit mReady(input mEntry_t e);
      return e.av && e.bv && (!e.uses || e.fv);
   endfunction

   function automatic int mSel();
      for (int k = 0; k < mq.size(); k++) if (mReady(mq[k])) return k;
      return -1;
   endfunction

   // First matching port in ascending order supplies the value.
   function automatic mEntry_t mWake(input mEntry_t e);
      mEntry_t r = e;
      bit gotA = e.av, gotB = e.bv, gotF = e.fv;
      for (int p = 0; p < NB; p++) begin
         if (in_bcast_valid[p]) begin
            if (!gotA && in_bcast_index[p*RW +: RW] == e.atag) begin
               gotA = 1; r.av = 1'b1; r.aval = in_bcast_value[p*GW +: GW];
            end
            if (!gotB && in_bcast_index[p*RW +: RW] == e.btag) begin
               gotB = 1; r.bv = 1'b1; r.bval = in_bcast_value[p*GW +: GW];
            end
            if (!gotF && in_bcast_set_nzcv[p] && in_bcast_index[p*RW +: RW] == e.ftag) begin
               gotF = 1; r.fv = 1'b1; r.f = in_bcast_nzcv[p*4 +: 4];
            end
         end
      end
      return r;
   endfunction

   task automatic checkModel();
      int sel;
      sel = mSel();
      checkOutput("occupancy", 64'(out_occupancy), 64'(mq.size()));
      checkOutput("disp_ready", 64'(out_disp_ready), 64'(mq.size() != RS));
      checkOutput("issue_valid", 64'(out_issue_valid), 64'(sel >= 0));
      if (sel >= 0) begin
         checkOutput("issue_op", 64'(out_issue_op), 64'(mq[sel].op));
         checkOutput("issue_val_a", 64'(out_issue_val_a), 64'(mq[sel].aval));
         checkOutput("issue_val_b", 64'(out_issue_val_b), 64'(mq[sel].bval));
         checkOutput("issue_dst", 64'(out_issue_dst_rob_index), 64'(mq[sel].dst));
         checkOutput("issue_set_nzcv", 64'(out_issue_set_nzcv), 64'(mq[sel].setf));
         checkOutput("issue_cond", 64'(out_issue_cond), 64'(mq[sel].cond));
         if (mq[sel].uses) checkOutput("issue_nzcv", 64'(out_issue_nzcv), 64'(mq[sel].f));
      end
   endtask

   // Called just after the edge while the pre-edge inputs are still held.
   task automatic mUpdate();
      int sel, sizeBefore;
      mEntry_t e;
      sel = mSel();
      sizeBefore = mq.size();
      if (!in_rst_n || in_flush) begin
         mq.delete();
         return;
      end
      if (sel >= 0 && in_fu_ready) mq.delete(sel);
      foreach (mq[k]) mq[k] = mWake(mq[k]);
      if (in_disp_valid && sizeBefore < RS) begin
         e.op = in_disp_op; e.dst = in_disp_dst_rob_index;
         e.av = in_disp_a_valid; e.aval = in_disp_a_value; e.atag = in_disp_a_rob_index;
         e.bv = in_disp_b_valid; e.bval = in_disp_b_value; e.btag = in_disp_b_rob_index;
         e.uses = in_disp_uses_nzcv; e.setf = in_disp_set_nzcv; e.fv = in_disp_nzcv_valid;
         e.f = in_disp_nzcv; e.ftag = in_disp_nzcv_rob_index; e.cond = in_disp_cond;
         mq.push_back(mWake(e));
      end
   endtask

   task automatic applyStimulus();
      #2;
      checkModel();
      @(posedge in_clk);
      mUpdate();
      #1;
   endtask

   initial begin
      clearInputs();
      in_rst_n = 1'b0;
      repeat (2) @(posedge in_clk);
      #1;
      clearInputs();
      mq.delete();
      #1;
      checkOutput("rst_occupancy", 64'(out_occupancy), 64'(0));
      checkOutput("rst_issue_valid", 64'(out_issue_valid), 64'(0));
      checkOutput("rst_disp_ready", 64'(out_disp_ready), 64'(1));
      checkOutput("rst_val_a", 64'(out_issue_val_a), 64'(0));
      checkOutput("rst_dst", 64'(out_issue_dst_rob_index), 64'(0));

      // Simple add: ready at dispatch, issues the following cycle.
      setDispatch(4'h1, 5'd1, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
      in_fu_ready = 1'b1;
      applyStimulus();
      clearInputs(); in_fu_ready = 1'b1; #1;
      checkOutput("add_issue_valid", 64'(out_issue_valid), 64'(1));
      checkOutput("add_val_a", 64'(out_issue_val_a), 64'(5));
      checkOutput("add_val_b", 64'(out_issue_val_b), 64'(7));
      checkOutput("add_dst", 64'(out_issue_dst_rob_index), 64'(1));
      checkOutput("add_occ_before", 64'(out_occupancy), 64'(1));
      applyStimulus();
      clearInputs(); #1;
      checkOutput("add_occ_after", 64'(out_occupancy), 64'(0));

      // Tag 3 waits on ROB 9; tags 4 and 5 pass it, then the broadcast releases tag 3.
      setDispatch(4'h2, 5'd3, 1'b0, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0); in_fu_ready = 1'b1; applyStimulus();
      clearInputs(); setDispatch(4'h2, 5'd4, 1'b1, 32'd2, 5'd0, 1'b1, 32'd3, 5'd0); in_fu_ready = 1'b1; applyStimulus();
      clearInputs(); setDispatch(4'h2, 5'd5, 1'b1, 32'd4, 5'd0, 1'b1, 32'd5, 5'd0); in_fu_ready = 1'b1; #1;
      checkOutput("order_first", 64'(out_issue_dst_rob_index), 64'(4));
      applyStimulus();
      clearInputs(); in_fu_ready = 1'b1; #1;
      checkOutput("order_second", 64'(out_issue_dst_rob_index), 64'(5));
      applyStimulus();
      clearInputs(); setBcast(0, 5'd9, 32'd42); in_fu_ready = 1'b1; #1;
      checkOutput("order_wait_valid", 64'(out_issue_valid), 64'(0));
      applyStimulus();
      clearInputs(); in_fu_ready = 1'b1; #1;
      checkOutput("order_third", 64'(out_issue_dst_rob_index), 64'(3));
      checkOutput("order_third_val_a", 64'(out_issue_val_a), 64'(42));
      applyStimulus();

      // Fill the station with waiting entries, try one more, then wake slot 2.
      for (int i = 0; i < RS; i++) begin
         clearInputs();
         setDispatch(4'h3, 5'(20 + i), 1'b0, 32'd0, 5'(10 + i), 1'b1, 32'(i), 5'd0);
         applyStimulus();
      end
      clearInputs(); setDispatch(4'h4, 5'd31, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0); in_fu_ready = 1'b1; #1;
      checkOutput("full_disp_ready", 64'(out_disp_ready), 64'(0));
      checkOutput("full_occupancy", 64'(out_occupancy), 64'(8));
      applyStimulus();
      clearInputs(); setBcast(0, 5'd12, 32'd77); in_fu_ready = 1'b1; applyStimulus();
      clearInputs(); in_fu_ready = 1'b1; #1;
      checkOutput("full_wake_dst", 64'(out_issue_dst_rob_index), 64'(22));
      checkOutput("full_wake_val_a", 64'(out_issue_val_a), 64'(77));
      applyStimulus();
      clearInputs(); #1;
      checkOutput("full_after_ready", 64'(out_disp_ready), 64'(1));
      checkOutput("full_after_occ", 64'(out_occupancy), 64'(7));
      in_flush = 1'b1; applyStimulus();

      // Same-cycle capture from port 1 at dispatch.
      clearInputs(); setDispatch(4'h5, 5'd7, 1'b0, 32'd0, 5'd6, 1'b1, 32'd1, 5'd0);
      setBcast(1, 5'd6, 32'd99); in_fu_ready = 1'b1; applyStimulus();
      clearInputs(); in_fu_ready = 1'b1; #1;
      checkOutput("capture_valid", 64'(out_issue_valid), 64'(1));
      checkOutput("capture_val_a", 64'(out_issue_val_a), 64'(99));
      applyStimulus();

      // Two ports carry the same tag; port 0 must win.
      clearInputs(); setDispatch(4'h6, 5'd8, 1'b0, 32'd0, 5'd2, 1'b1, 32'd1, 5'd0); applyStimulus();
      clearInputs(); setBcast(0, 5'd2, 32'd11); setBcast(1, 5'd2, 32'd22); applyStimulus();
      clearInputs(); in_fu_ready = 1'b1; #1;
      checkOutput("prio_val_a", 64'(out_issue_val_a), 64'(11));
      applyStimulus();

      // Flush with five entries and a simultaneous dispatch.
      for (int i = 0; i < 5; i++) begin
         clearInputs(); setDispatch(4'h7, 5'(12 + i), 1'b0, 32'd0, 5'(25 + i), 1'b1, 32'd0, 5'd0);
         applyStimulus();
      end
      clearInputs(); setDispatch(4'h8, 5'd30, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2, 5'd0);
      in_flush = 1'b1; in_fu_ready = 1'b1; #1;
      checkOutput("flush_occ_before", 64'(out_occupancy), 64'(5));
      applyStimulus();
      clearInputs(); in_fu_ready = 1'b1; #1;
      checkOutput("flush_occ_after", 64'(out_occupancy), 64'(0));
      checkOutput("flush_issue_valid", 64'(out_issue_valid), 64'(0));
      applyStimulus();
      applyStimulus();

      // Random traffic with occasional flush and reset.
      for (int c = 0; c < 3000; c++) begin
         clearInputs();
         in_rst_n    = ($urandom_range(0, 199) != 0);
         in_flush    = ($urandom_range(0, 49) == 0);
         in_fu_ready = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) < 6) begin
            in_disp_valid = 1'b1;
            in_disp_op = 4'($urandom); in_disp_dst_rob_index = 5'($urandom);
            in_disp_a_valid = 1'($urandom_range(0, 1)); in_disp_a_value = $urandom;
            in_disp_a_rob_index = 5'($urandom_range(0, 7));
            in_disp_b_valid = 1'($urandom_range(0, 1)); in_disp_b_value = $urandom;
            in_disp_b_rob_index = 5'($urandom_range(0, 7));
            in_disp_uses_nzcv = 1'($urandom_range(0, 1)); in_disp_set_nzcv = 1'($urandom_range(0, 1));
            in_disp_nzcv_valid = 1'($urandom_range(0, 1)); in_disp_nzcv = 4'($urandom);
            in_disp_nzcv_rob_index = 5'($urandom_range(0, 7)); in_disp_cond = 4'($urandom);
         end
         for (int p = 0; p < NB; p++) begin
            if ($urandom_range(0, 9) < 4) begin
               setBcast(p, 5'($urandom_range(0, 7)), $urandom);
               in_bcast_set_nzcv[p] = 1'($urandom_range(0, 1));
               in_bcast_nzcv[p*4 +: 4] = 4'($urandom);
            end
         end
         applyStimulus();
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
